logic_gate_checker: RTL and testbench
=====================================

Name: logic_gate_checker

Overview:
- Result-checking stage directly downstream of the parameterised two-input logic gates (NOR and siblings).
- Consumes the gate's operands `a`, `b` and its result `z`, and recomputes the expected result for a selected gate function.
- Over a run of `NUM_VECTORS` accepted vectors, it counts mismatches and captures the first failure, then reports pass/fail.
- Used both in self-checking benches and in the on-board gate demo.

Parameters:
- WIDTH, 5: operand/result width in bits; must be ≥ 1.
- NUM_VECTORS, 10: vectors accepted per run; must be ≥ 1 and ≤ 65535.
- OP, 3: gate function checked. 0=AND, 1=OR, 2=NAND, 3=NOR, 4=XOR, 5=XNOR. 6 and 7 are reserved; for these, expected = all zeros.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  begins a run; honoured in IDLE and DONE only.
- in_valid  input  1  `a`, `b` and `z` are valid this cycle.
- a  input  WIDTH  operand A as driven into the gate.
- b  input  WIDTH  operand B as driven into the gate.
- z  input  WIDTH  gate result. The gate is combinational, so `z` is cycle-aligned with `a`/`b`.
- in_ready  output  1  checker accepts a vector this cycle.
- busy  output  1  run in progress.
- done  output  1  run complete; held high until the next start or reset.
- pass  output  1  equals `done && (err_count == 0)`.
- vec_count  output  16  vectors accepted in the current run.
- err_count  output  16  mismatches in the current run; saturates at 0xFFFF.
- first_err_idx  output  16  `vec_count` value at the first mismatch; 0xFFFF if there has been none.
- first_err_exp  output  WIDTH  expected value at the first mismatch.
- first_err_got  output  WIDTH  `z` at the first mismatch.

Behaviour:
- Reset is synchronous and active-high on `rst`, with a single clock `clk`.
- Reset (`rst` high at a rising edge) has priority over every other input. It produces:
  - state = IDLE;
  - `busy`, `done`, `pass`, `in_ready` = 0;
  - `vec_count`, `err_count` = 0;
  - `first_err_idx` = 0xFFFF;
  - `first_err_exp`, `first_err_got` = 0.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - `in_ready` = 0.
  - `start` = 1 → go to RUN. On the same edge, clear `vec_count` and `err_count`, set `first_err_idx` to 0xFFFF, and clear the capture registers.
- RUN:
  - `busy` = 1 and `in_ready` = 1.
  - A vector is accepted when `in_valid && in_ready` at an edge.
  - Acceptance: `vec_count` increments by 1.
  - Mismatch check: the vector is compared bitwise, full width, against expected (`exp`) = OP function of `a`, `b`. A mismatch is `exp != z`; any X or Z on `z` counts as a mismatch.
  - On a mismatch:
    - `err_count` increments, saturating at 0xFFFF;
    - if `first_err_idx` is 0xFFFF, capture `first_err_idx` = the pre-increment `vec_count`, `first_err_exp` = `exp` and `first_err_got` = `z`.
  - When the accepting edge brings `vec_count` to `NUM_VECTORS`, the next state is DONE.
  - `start` is ignored in RUN.
- Timing:
  - A vector's effect on the counters is visible immediately after its accepting edge.
  - `done` rises immediately after the edge that accepts the last vector, with zero idle cycles.
- DONE:
  - `done` = 1 and `busy` = 0.
  - `in_ready` = 0; `in_valid` is ignored.
  - All counters and captures hold.
  - `start` = 1 → restart exactly as from IDLE; `done` drops on that edge.
- Boundary conditions:
  - `in_valid` gaps in RUN: no change to any counter.
  - `NUM_VECTORS` = 1: a single accepted vector moves the block to DONE.
  - Reset mid-run: all state is discarded and the block returns to IDLE next cycle.
  - `start` and `rst` high together: reset wins.
  - `start` held high through DONE: the run restarts. `start` still high in the following RUN cycles is ignored.

Test Plan:
1. Reset check: assert `rst` for 2 cycles → all outputs at their reset values; `first_err_idx` = 0xFFFF.
2. Correct NOR model, `OP`=3, `WIDTH`=5, `NUM_VECTORS`=10: pulse `start`, then 10 valid vectors of random `a`/`b` with `z` = ~(`a`|`b`) → after the 10th accept, `done`=1, `pass`=1, `vec_count`=10, `err_count`=0.
3. Fault injection: same as 2, but vector 3 has `a`=5'h0A, `b`=5'h11, `z` forced to 5'h05 (expected 5'h04), and vector 7 is also corrupted → `err_count`=2, `first_err_idx`=3, `first_err_exp`=5'h04, `first_err_got`=5'h05, `pass`=0.
4. `in_valid` gaps: drop `in_valid` every other cycle → `done` only after 10 accepts (about 20 cycles). While `in_valid`=0, `vec_count` is unchanged. Extra vectors presented in DONE are not counted.
5. Reset mid-run: reset after 4 accepts → IDLE with `vec_count`=0. Then `start` and 10 clean vectors → `pass`=1.
6. Restart from DONE, and `OP`=4 (XOR) instance: `start` in DONE clears counters, and a second run of clean XOR vectors → `pass`=1. Vector `a`=5'h1F, `b`=5'h1F, `z`=5'h1F → 1 error with `first_err_exp`=5'h00.

Source files
------------

// File: rtl/logic_gate_checker.sv
// rtl/logic_gate_checker.sv - checks a two-input gate's result against a recomputed reference
module logic_gate_checker #(
   parameter int WIDTH       = 5,
   parameter int NUM_VECTORS = 10,
   parameter int OP          = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] z,
   output logic             in_ready,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [15:0]      vec_count,
   output logic [15:0]      err_count,
   output logic [15:0]      first_err_idx,
   output logic [WIDTH-1:0] first_err_exp,
   output logic [WIDTH-1:0] first_err_got
);

   localparam logic [1:0]  S_IDLE = 2'd0;
   localparam logic [1:0]  S_RUN  = 2'd1;
   localparam logic [1:0]  S_DONE = 2'd2;

   localparam logic [2:0]  OP_SEL   = 3'(OP);
   localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS);
   localparam logic [15:0] NO_ERR   = 16'hFFFF;

   logic [1:0]       state_q, state_d;
   logic [15:0]      vec_count_q, vec_count_d;
   logic [15:0]      err_count_q, err_count_d;
   logic [15:0]      first_err_idx_q, first_err_idx_d;
   logic [WIDTH-1:0] first_err_exp_q, first_err_exp_d;
   logic [WIDTH-1:0] first_err_got_q, first_err_got_d;

   logic [WIDTH-1:0] exp_val;
   logic             mismatch;
   logic             accept;

   // Reference gate function; reserved encodings expect all zeros
   always_comb begin
      exp_val = '0;
      case (OP_SEL)
         3'd0:    exp_val = a & b;
         3'd1:    exp_val = a | b;
         3'd2:    exp_val = ~(a & b);
         3'd3:    exp_val = ~(a | b);
         3'd4:    exp_val = a ^ b;
         3'd5:    exp_val = ~(a ^ b);
         default: exp_val = '0;
      endcase
   end

   // Mismatch written as if/else so an unknown z falls into the mismatch branch
   always_comb begin
      mismatch = 1'b1;
      if (exp_val == z) begin
         mismatch = 1'b0;
      end else begin
         mismatch = 1'b1;
      end
   end

   assign accept = (state_q == S_RUN) && in_valid;

   // Next-state and counter/capture update
   always_comb begin
      state_d         = state_q;
      vec_count_d     = vec_count_q;
      err_count_d     = err_count_q;
      first_err_idx_d = first_err_idx_q;
      first_err_exp_d = first_err_exp_q;
      first_err_got_d = first_err_got_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d         = S_RUN;
               vec_count_d     = '0;
               err_count_d     = '0;
               first_err_idx_d = NO_ERR;
               first_err_exp_d = '0;
               first_err_got_d = '0;
            end
         end
         S_RUN: begin
            if (accept) begin
               vec_count_d = vec_count_q + 16'd1;
               if (mismatch) begin
                  if (err_count_q != 16'hFFFF) begin
                     err_count_d = err_count_q + 16'd1;
                  end
                  if (first_err_idx_q == NO_ERR) begin
                     first_err_idx_d = vec_count_q;
                     first_err_exp_d = exp_val;
                     first_err_got_d = z;
                  end
               end
               if (vec_count_q + 16'd1 == LAST_VEC) begin
                  state_d = S_DONE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers with synchronous reset taking priority
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         vec_count_q     <= '0;
         err_count_q     <= '0;
         first_err_idx_q <= NO_ERR;
         first_err_exp_q <= '0;
         first_err_got_q <= '0;
      end else begin
         state_q         <= state_d;
         vec_count_q     <= vec_count_d;
         err_count_q     <= err_count_d;
         first_err_idx_q <= first_err_idx_d;
         first_err_exp_q <= first_err_exp_d;
         first_err_got_q <= first_err_got_d;
      end
   end

   assign in_ready      = (state_q == S_RUN);
   assign busy          = (state_q == S_RUN);
   assign done          = (state_q == S_DONE);
   assign pass          = done && (err_count_q == 16'd0);
   assign vec_count     = vec_count_q;
   assign err_count     = err_count_q;
   assign first_err_idx = first_err_idx_q;
   assign first_err_exp = first_err_exp_q;
   assign first_err_got = first_err_got_q;

endmodule

// File: tb/tb_logic_gate_checker.sv
// tb/tb_logic_gate_checker.sv - directed self-checking bench for logic_gate_checker
module tb_logic_gate_checker;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [4:0] a, b, z_n, z_x, z_1;
   logic       start_n, start_x, start_1;

   logic        n_ready, n_busy, n_done, n_pass;
   logic [15:0] n_vec, n_err, n_idx;
   logic [4:0]  n_exp, n_got;
   logic        x_ready, x_busy, x_done, x_pass;
   logic [15:0] x_vec, x_err, x_idx;
   logic [4:0]  x_exp, x_got;
   logic        o_ready, o_busy, o_done, o_pass;
   logic [15:0] o_vec, o_err, o_idx;
   logic [4:0]  o_exp, o_got;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   logic_gate_checker #(.WIDTH(5), .NUM_VECTORS(10), .OP(3)) dut_nor (
      .clk(clk), .rst(rst), .start(start_n), .in_valid(in_valid),
      .a(a), .b(b), .z(z_n), .in_ready(n_ready), .busy(n_busy),
      .done(n_done), .pass(n_pass), .vec_count(n_vec), .err_count(n_err),
      .first_err_idx(n_idx), .first_err_exp(n_exp), .first_err_got(n_got)
   );

   logic_gate_checker #(.WIDTH(5), .NUM_VECTORS(10), .OP(4)) dut_xor (
      .clk(clk), .rst(rst), .start(start_x), .in_valid(in_valid),
      .a(a), .b(b), .z(z_x), .in_ready(x_ready), .busy(x_busy),
      .done(x_done), .pass(x_pass), .vec_count(x_vec), .err_count(x_err),
      .first_err_idx(x_idx), .first_err_exp(x_exp), .first_err_got(x_got)
   );

   logic_gate_checker #(.WIDTH(5), .NUM_VECTORS(1), .OP(0)) dut_one (
      .clk(clk), .rst(rst), .start(start_1), .in_valid(in_valid),
      .a(a), .b(b), .z(z_1), .in_ready(o_ready), .busy(o_busy),
      .done(o_done), .pass(o_pass), .vec_count(o_vec), .err_count(o_err),
      .first_err_idx(o_idx), .first_err_exp(o_exp), .first_err_got(o_got)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input logic [4:0] av, input logic [4:0] bv,
                        input logic [4:0] zn, input logic [4:0] zx);
      a = av; b = bv; z_n = zn; z_x = zx; z_1 = av & bv;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic clean(input logic [4:0] av, input logic [4:0] bv);
      apply(av, bv, ~(av | bv), av ^ bv);
   endtask

   task automatic pulse_nor();
      start_n = 1'b1;
      tick();
      start_n = 1'b0;
   endtask

   initial begin
      logic [4:0] ra, rb;
      logic [15:0] prev;
      int cyc;

      rst = 1'b1; start_n = 0; start_x = 0; start_1 = 0; in_valid = 0;
      a = 0; b = 0; z_n = 0; z_x = 0; z_1 = 0;

      // Reset state
      tick(); tick();
      rst = 1'b0;
      check("rst_busy",     32'(n_busy),  32'd0);
      check("rst_done",     32'(n_done),  32'd0);
      check("rst_pass",     32'(n_pass),  32'd0);
      check("rst_ready",    32'(n_ready), 32'd0);
      check("rst_vec",      32'(n_vec),   32'd0);
      check("rst_err",      32'(n_err),   32'd0);
      check("rst_idx",      32'(n_idx),   32'hFFFF);
      check("rst_exp",      32'(n_exp),   32'd0);
      check("rst_got",      32'(n_got),   32'd0);

      // Idle ignores vectors
      clean(5'h03, 5'h04);
      check("idle_vec", 32'(n_vec), 32'd0);

      // Clean NOR run
      pulse_nor();
      check("run_busy",  32'(n_busy),  32'd1);
      check("run_ready", 32'(n_ready), 32'd1);
      for (int i = 0; i < 10; i++) begin
         ra = 5'($urandom); rb = 5'($urandom);
         check("run_notdone", 32'(n_done), 32'd0);
         clean(ra, rb);
      end
      check("run_done", 32'(n_done), 32'd1);
      check("run_busy_lo", 32'(n_busy), 32'd0);
      check("run_pass", 32'(n_pass), 32'd1);
      check("run_vec",  32'(n_vec),  32'd10);
      check("run_err",  32'(n_err),  32'd0);

      // Fault injection at vectors 3 and 7
      pulse_nor();
      check("flt_clr_vec", 32'(n_vec), 32'd0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) apply(5'h0A, 5'h11, 5'h05, 5'h1B);
         else if (i == 7) apply(5'h00, 5'h00, 5'h00, 5'h00);
         else clean(5'(i), 5'(i * 3));
      end
      check("flt_done", 32'(n_done), 32'd1);
      check("flt_err",  32'(n_err),  32'd2);
      check("flt_idx",  32'(n_idx),  32'd3);
      check("flt_exp",  32'(n_exp),  32'h04);
      check("flt_got",  32'(n_got),  32'h05);
      check("flt_pass", 32'(n_pass), 32'd0);

      // in_valid gaps
      pulse_nor();
      check("gap_clr_idx", 32'(n_idx), 32'hFFFF);
      cyc = 0;
      while (!n_done && cyc < 100) begin
         ra = 5'($urandom); rb = 5'($urandom);
         a = ra; b = rb; z_n = ~(ra | rb); z_x = ra ^ rb; z_1 = ra & rb;
         in_valid = (cyc % 2 == 0);
         prev = n_vec;
         tick();
         if (!in_valid) check("gap_hold", 32'(n_vec), 32'(prev));
         cyc++;
      end
      in_valid = 1'b0;
      check("gap_done",   32'(n_done), 32'd1);
      check("gap_cycles", 32'(cyc),    32'd19);
      clean(5'h01, 5'h02);
      clean(5'h04, 5'h08);
      check("gap_extra_vec", 32'(n_vec),  32'd10);
      check("gap_extra_dn",  32'(n_done), 32'd1);
      check("gap_pass",      32'(n_pass), 32'd1);

      // Reset mid-run, then start with reset together
      pulse_nor();
      for (int i = 0; i < 4; i++) clean(5'(i + 1), 5'(i));
      check("mid_vec4", 32'(n_vec), 32'd4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_busy",  32'(n_busy),  32'd0);
      check("mid_ready", 32'(n_ready), 32'd0);
      check("mid_vec",   32'(n_vec),   32'd0);
      check("mid_idx",   32'(n_idx),   32'hFFFF);
      rst = 1'b1; start_n = 1'b1;
      tick();
      rst = 1'b0; start_n = 1'b0;
      check("rst_wins", 32'(n_busy), 32'd0);
      pulse_nor();
      for (int i = 0; i < 10; i++) clean(5'(i * 7), 5'(i * 5));
      check("mid_pass", 32'(n_pass), 32'd1);
      check("mid_vec10", 32'(n_vec), 32'd10);

      // XOR instance: clean run, then restart with start held
      start_x = 1'b1;
      tick();
      start_x = 1'b0;
      for (int i = 0; i < 10; i++) clean(5'($urandom), 5'($urandom));
      check("xor_pass", 32'(x_pass), 32'd1);
      start_x = 1'b1;
      tick();
      check("xor_rs_busy", 32'(x_busy), 32'd1);
      check("xor_rs_done", 32'(x_done), 32'd0);
      check("xor_rs_vec",  32'(x_vec),  32'd0);
      apply(5'h1F, 5'h1F, 5'h00, 5'h1F);
      start_x = 1'b0;
      check("xor_held_vec", 32'(x_vec), 32'd1);
      check("xor_err1", 32'(x_err), 32'd1);
      check("xor_idx",  32'(x_idx), 32'd0);
      check("xor_exp",  32'(x_exp), 32'h00);
      check("xor_got",  32'(x_got), 32'h1F);
      for (int i = 0; i < 9; i++) clean(5'(i), 5'(i + 9));
      check("xor_done", 32'(x_done), 32'd1);
      check("xor_err",  32'(x_err),  32'd1);
      check("xor_fail", 32'(x_pass), 32'd0);

      // NUM_VECTORS = 1 instance
      start_1 = 1'b1;
      tick();
      start_1 = 1'b0;
      check("one_busy", 32'(o_busy), 32'd1);
      clean(5'h16, 5'h0D);
      check("one_done", 32'(o_done), 32'd1);
      check("one_pass", 32'(o_pass), 32'd1);
      check("one_vec",  32'(o_vec),  32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
